namuru_dump_scheduler: RTL and testbench
========================================

# namuru_dump_scheduler

Captures correlator accumulation results from up to NCH tracking channels into a shared snapshot buffer whenever a channel dumps, so firmware reads stable values at leisure. Sits between the tracking-channel array and the Wishbone register file in the GPS baseband. Channels that dump at the same time are served round-robin through one shared accumulator-word mux. The block maintains the per-channel new_data and overrun bitmaps and the data-ready interrupt.

## Interface
- NCH, 12, number of tracking channels (1..16)
- IDXW, 4, width of the channel index, = clog2(NCH) with a minimum of 1
- correlator_clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- dump  in  NCH  per-channel dump pulses, one cycle wide
- sel_ch  out  IDXW  channel index driven to the accumulator mux
- sel_word  out  3  word index to the mux: 0=i_early, 1=q_early, 2=i_prompt, 3=q_prompt, 4=i_late, 5=q_late
- acc_word  in  16  mux output for sel_ch/sel_word, combinational, same cycle
- rd_addr  in  IDXW+3  snapshot read address = {channel, word}
- rd_data  out  16  snapshot word, registered
- new_data  out  NCH  snapshot-complete flags
- nd_clr  in  1  clear strobe for new_data
- nd_clr_mask  in  NCH  bits of new_data to clear on nd_clr
- overrun  out  NCH  missed or torn-capture flags
- ov_clr  in  1  clears all overrun bits
- data_irq  out  1  registered copy of |new_data
- busy  out  1  high while state = COPY

## Operation
- pending[NCH]: set by dump[c]. Cleared for channel c on the cycle c is granted.
- Overrun[c] is set when either of these happens:
  - dump[c] arrives while pending[c] is already 1;
  - dump[c] arrives while channel c is in COPY.
- In both overrun cases pending[c] still ends up 1, so the channel is captured again.
- State IDLE:
  - If pending is nonzero, grant the first set bit found searching from last_grant+1, wrapping modulo NCH.
  - Load cur_ch, set word=0, set last_grant=cur_ch, go to COPY.
- State COPY:
  - sel_ch=cur_ch, sel_word=word.
  - Each cycle, write mem[{cur_ch, word}] <= acc_word and increment word.
  - On the cycle with word==5, set new_data[cur_ch] and return to IDLE.
- Outside COPY: sel_ch=last_grant and sel_word=0. No memory write occurs.
- new_data update each cycle: new_data <= (new_data & ~(nd_clr ? nd_clr_mask : 0)) | set_vec. A set wins over a same-cycle clear.
- overrun update: the same rule with ov_clr clearing all bits. A same-cycle set wins.
- Memory size is NCH×8 words. Word addresses 6 and 7 of each channel read as 0. Addresses with channel ≥ NCH read as 0.
- Reset values:
  - pending, new_data, overrun, data_irq, busy, rd_data, word, cur_ch: all 0.
  - last_grant = NCH-1, so channel 0 wins first.
  - state = IDLE.
  - Memory contents are not reset.
- Reset asserted mid-COPY aborts immediately. Partially written words remain in memory, and new_data for that channel is not set.

## Timing
- Dump sampled at edge E0 → pending set after E0.
- Grant at E1.
- Words 0..5 written at E2..E7.
- new_data bit visible after E7; data_irq one edge later, at E8.
- The state machine returns to IDLE after E7, and the next grant is no earlier than E8.
- Service time is 7 cycles per channel. The worst case for NCH=12 is 84 cycles, well below the 1 ms dump period.
- rd_data returns mem[rd_addr] one edge after rd_addr is presented. A read of a word written on the same edge returns the old value.

## Structure
- Shared package namuru_pkg holds:
  - NUM_ACC_WORDS=6;
  - the word-index constants (W_IE..W_QL);
  - the state enum {IDLE, COPY};
  - the IDXW helper function.
- Sub-module namuru_rr_arb: parameterised round-robin priority search, taking the request vector and last_grant and returning the grant index and a valid flag. It is purely combinational.
- The snapshot memory is an inferred register array inside the top module.

## Test plan
- Single dump: dump[3] at E0 with the mux returning 16'h1000+word → words 0..5 of channel 3 hold 1000..1005. new_data = 12'h008 after E7 and data_irq after E8. rd_addr={3,2} returns 16'h1002 one cycle later.
- Simultaneous dumps on channels 0, 5 and 11 with last_grant=4 → service order 5, 11, 0. The three new_data bits rise at E7, E14 and E21.
- Clear collision: nd_clr with mask 12'h004 issued on the same cycle channel 2 completes → new_data[2] stays 1. A later clear with no collision → bit 2 goes to 0 and data_irq drops one cycle later.
- Overrun, two cases:
  - Channel 7 dumps twice before being granted → overrun[7]=1 and a single capture.
  - Channel 4 dumps during its own COPY → overrun[4]=1 and a second capture follows.
  - ov_clr then clears both bits.
- Reset mid-COPY at word 3 → all flags return to 0, state is IDLE, busy is 0, and no new_data bit is set. A subsequent dump on channel 0 is served normally.

Source files
------------

// File: rtl/namuru_pkg.sv
// Shared constants and types for the namuru dump scheduler.
// Word indices follow the correlator accumulator order.
package namuru_pkg;

  localparam int NUM_ACC_WORDS = 6;

  localparam logic [2:0] W_IE = 3'd0;
  localparam logic [2:0] W_QE = 3'd1;
  localparam logic [2:0] W_IP = 3'd2;
  localparam logic [2:0] W_QP = 3'd3;
  localparam logic [2:0] W_IL = 3'd4;
  localparam logic [2:0] W_QL = 3'd5;

  typedef enum logic {
    IDLE,
    COPY
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/namuru_dump_scheduler_if.sv
// Bus between the dump scheduler, the channel array,
// the accumulator mux and the register file.
interface namuru_dump_scheduler_if #(
  parameter int NCH  = 12,
  parameter int IDXW = 4
);

  logic [NCH-1:0]  dump;
  logic [IDXW-1:0] sel_ch;
  logic [2:0]      sel_word;
  logic [15:0]     acc_word;
  logic [IDXW+2:0] rd_addr;
  logic [15:0]     rd_data;
  logic [NCH-1:0]  new_data;
  logic            nd_clr;
  logic [NCH-1:0]  nd_clr_mask;
  logic [NCH-1:0]  overrun;
  logic            ov_clr;
  logic            data_irq;
  logic            busy;

  modport master (
    input  dump, acc_word, rd_addr,
    input  nd_clr, nd_clr_mask, ov_clr,
    output sel_ch, sel_word, rd_data,
    output new_data, overrun,
    output data_irq, busy
  );

  modport slave (
    output dump, acc_word, rd_addr,
    output nd_clr, nd_clr_mask, ov_clr,
    input  sel_ch, sel_word, rd_data,
    input  new_data, overrun,
    input  data_irq, busy
  );

endinterface

// File: rtl/namuru_rr_arb.sv
// Round-robin priority search: first request
// after last, wrapping modulo N.
module namuru_rr_arb
  import namuru_pkg::*;
#(
  parameter int N = 12,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] gnt,
  output logic         valid
);

  always_comb begin
    int k;
    gnt   = '0;
    valid = 1'b0;
    k     = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(last) + i) % N;
      if (!valid && req[k]) begin
        valid = 1'b1;
        gnt   = W'(k);
      end
    end
  end

endmodule

// File: rtl/namuru_dump_scheduler.sv
// Snapshots dumping channels' accumulators into a shared
// buffer, one channel at a time, round-robin.
module namuru_dump_scheduler
  import namuru_pkg::*;
#(
  parameter int NCH  = 12,
  parameter int IDXW = idx_w(NCH)
) (
  input logic correlator_clk,
  input logic rstn,
  namuru_dump_scheduler_if.master bus
);

  state_t state, state_d;

  logic [IDXW-1:0] cur_ch, last_grant;
  logic [IDXW-1:0] arb_gnt;
  logic            arb_valid;
  logic [2:0]      word;
  logic            copy, grant, done;

  logic [NCH-1:0] pending, nd_q, ov_q;
  logic [NCH-1:0] grant_vec, nd_set;
  logic [NCH-1:0] ov_set, copy_vec;
  logic [NCH-1:0] nd_clr_vec;
  logic           irq_q;
  logic [15:0]    rd_q;

  logic [15:0]     mem [NCH*8];
  logic [IDXW+2:0] wr_addr;
  logic [IDXW-1:0] rd_ch;
  logic [2:0]      rd_w;
  logic            rd_ok;

  namuru_rr_arb #(
    .N (NCH),
    .W (IDXW)
  ) u_arb (
    .req   (pending),
    .last  (last_grant),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  always_comb begin
    state_d   = state;
    grant     = 1'b0;
    done      = 1'b0;
    grant_vec = '0;
    nd_set    = '0;
    unique case (state)
      IDLE: begin
        if (arb_valid) begin
          grant              = 1'b1;
          grant_vec[arb_gnt] = 1'b1;
          state_d            = COPY;
        end
      end
      COPY: begin
        if (word == W_QL) begin
          done           = 1'b1;
          nd_set[cur_ch] = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign copy = (state == COPY);

  // Overrun: re-dump while still queued or mid-copy.
  always_comb begin
    copy_vec = '0;
    if (copy) copy_vec[cur_ch] = 1'b1;
  end

  assign ov_set     = bus.dump & (pending | copy_vec);
  assign nd_clr_vec = bus.nd_clr ? bus.nd_clr_mask : '0;

  always_ff @(posedge correlator_clk) begin
    if (!rstn) begin
      state      <= IDLE;
      cur_ch     <= '0;
      word       <= '0;
      last_grant <= IDXW'(NCH - 1);
      pending    <= '0;
      nd_q       <= '0;
      ov_q       <= '0;
      irq_q      <= 1'b0;
    end else begin
      state   <= state_d;
      pending <= (pending & ~grant_vec) | bus.dump;
      nd_q    <= (nd_q & ~nd_clr_vec) | nd_set;
      ov_q    <= (bus.ov_clr ? '0 : ov_q) | ov_set;
      irq_q   <= |nd_q;
      if (grant) begin
        cur_ch     <= arb_gnt;
        last_grant <= arb_gnt;
        word       <= W_IE;
      end else if (done) begin
        word <= W_IE;
      end else if (copy) begin
        word <= word + 3'd1;
      end
    end
  end

  assign wr_addr = {cur_ch, word};

  always_ff @(posedge correlator_clk) begin
    if (rstn && copy) mem[wr_addr] <= bus.acc_word;
  end

  assign rd_ch = bus.rd_addr[IDXW+2:3];
  assign rd_w  = bus.rd_addr[2:0];
  assign rd_ok = (int'(rd_ch) < NCH) &&
                 (int'(rd_w) < NUM_ACC_WORDS);

  always_ff @(posedge correlator_clk) begin
    if (!rstn) rd_q <= '0;
    else       rd_q <= rd_ok ? mem[bus.rd_addr] : '0;
  end

  assign bus.sel_ch   = copy ? cur_ch : last_grant;
  assign bus.sel_word = copy ? word : W_IE;
  assign bus.rd_data  = rd_q;
  assign bus.new_data = nd_q;
  assign bus.overrun  = ov_q;
  assign bus.data_irq = irq_q;
  assign bus.busy     = copy;

endmodule

// File: tb/tb_namuru_dump_scheduler.sv
// Directed plus random bench for namuru_dump_scheduler,
// checked against a transaction-level schedule model.
module tb_namuru_dump_scheduler;
  import namuru_pkg::*;

  localparam int NCH  = 12;
  localparam int IDXW = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  namuru_dump_scheduler_if #(
    .NCH (NCH),
    .IDXW(IDXW)
  ) bus ();

  namuru_dump_scheduler #(
    .NCH (NCH),
    .IDXW(IDXW)
  ) dut (
    .correlator_clk(clk),
    .rstn          (rstn),
    .bus           (bus)
  );

  // Mux model: each channel's words are base + word index.
  logic [15:0] base [16];
  always_comb
    bus.acc_word = base[bus.sel_ch] + 16'(bus.sel_word);

  int checks = 0;
  int errors = 0;
  int m_last;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_nd;
    bus.nd_clr      = 1'b1;
    bus.nd_clr_mask = '1;
    tick;
    bus.nd_clr      = 1'b0;
    bus.nd_clr_mask = '0;
    tick;
  endtask

  task automatic read_chk(input int c, input int w,
                          input logic [15:0] exp,
                          input string tag);
    bus.rd_addr = 7'(c * 8 + w);
    tick;
    check(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  // Simultaneous dumps on mask: predict order and completion times.
  task automatic run_burst(input logic [NCH-1:0] mask,
                           input string tag);
    int order[$];
    int n;
    logic [NCH-1:0] exp_nd;
    for (int i = 1; i <= NCH; i++) begin
      int c;
      c = (m_last + i) % NCH;
      if (mask[c]) order.push_back(c);
    end
    n      = order.size();
    m_last = order[n-1];
    bus.dump = mask;
    tick;
    bus.dump = '0;
    exp_nd   = '0;
    for (int t = 1; t <= 7 * n + 1; t++) begin
      tick;
      for (int k = 0; k < n; k++)
        if (t == 7 + 7 * k) exp_nd[order[k]] = 1'b1;
      check({tag, ".nd"}, 32'(bus.new_data), 32'(exp_nd));
      check({tag, ".busy"}, 32'(bus.busy),
            32'(t <= 7 * n && t % 7 != 0));
      check({tag, ".irq"}, 32'(bus.data_irq), 32'(t >= 8));
    end
    check({tag, ".last"}, 32'(bus.sel_ch), 32'(m_last));
    for (int k = 0; k < n; k++)
      for (int w = 0; w < NUM_ACC_WORDS; w++)
        read_chk(order[k], w,
                 base[order[k]] + 16'(w), {tag, ".mem"});
    check({tag, ".ov"}, 32'(bus.overrun), 32'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [NCH-1:0] m;
    rstn            = 1'b0;
    bus.dump        = '0;
    bus.nd_clr      = 1'b0;
    bus.nd_clr_mask = '0;
    bus.ov_clr      = 1'b0;
    bus.rd_addr     = '0;
    for (int i = 0; i < 16; i++) base[i] = '0;
    m_last = NCH - 1;
    repeat (3) tick;
    check("rst.nd", 32'(bus.new_data), 32'(0));
    check("rst.ov", 32'(bus.overrun), 32'(0));
    check("rst.busy", 32'(bus.busy), 32'(0));
    check("rst.irq", 32'(bus.data_irq), 32'(0));
    check("rst.sel_ch", 32'(bus.sel_ch), 32'(NCH - 1));
    check("rst.sel_w", 32'(bus.sel_word), 32'(0));
    check("rst.rd", 32'(bus.rd_data), 32'(0));
    rstn = 1'b1;
    tick;

    base[3] = 16'h1000;
    run_burst(12'h008, "single");
    read_chk(3, 2, 16'h1002, "rd32");
    read_chk(3, 6, 16'h0000, "w6");
    read_chk(3, 7, 16'h0000, "w7");
    read_chk(12, 0, 16'h0000, "ch12");
    read_chk(15, 1, 16'h0000, "ch15");
    clear_nd;
    check("clr.irq", 32'(bus.data_irq), 32'(0));

    base[4] = 16'($urandom);
    run_burst(12'h010, "ch4");
    clear_nd;
    base[0]  = 16'($urandom);
    base[5]  = 16'($urandom);
    base[11] = 16'($urandom);
    run_burst(12'h821, "simul");
    clear_nd;

    for (int it = 0; it < 15; it++) begin
      m = NCH'($urandom);
      if (m == '0) m[$urandom_range(0, NCH - 1)] = 1'b1;
      for (int c = 0; c < NCH; c++)
        if (m[c]) base[c] = 16'($urandom);
      run_burst(m, "rand");
      clear_nd;
    end

    // Clear on the completion edge loses to the set.
    base[2]  = 16'($urandom);
    bus.dump = 12'h004;
    tick;
    bus.dump = '0;
    repeat (6) tick;
    bus.nd_clr      = 1'b1;
    bus.nd_clr_mask = 12'h004;
    tick;
    bus.nd_clr      = 1'b0;
    bus.nd_clr_mask = '0;
    check("coll.nd", 32'(bus.new_data), 32'h004);
    tick;
    check("coll.irq", 32'(bus.data_irq), 32'(1));
    bus.nd_clr      = 1'b1;
    bus.nd_clr_mask = 12'h004;
    tick;
    bus.nd_clr      = 1'b0;
    bus.nd_clr_mask = '0;
    check("clr2.nd", 32'(bus.new_data), 32'(0));
    check("clr2.irq1", 32'(bus.data_irq), 32'(1));
    tick;
    check("clr2.irq0", 32'(bus.data_irq), 32'(0));

    // Channel 7 dumps twice while channel 6 is copying.
    base[6]  = 16'($urandom);
    base[7]  = 16'($urandom);
    bus.dump = 12'h040;
    tick;
    bus.dump = '0;
    tick;
    bus.dump = 12'h080;
    tick;
    check("ov1.pre", 32'(bus.overrun), 32'(0));
    tick;
    bus.dump = '0;
    check("ov1.set", 32'(bus.overrun), 32'h080);
    repeat (4) tick;
    check("ov1.nd6", 32'(bus.new_data), 32'h040);
    repeat (7) tick;
    check("ov1.nd7", 32'(bus.new_data), 32'h0c0);
    repeat (6) tick;
    check("ov1.once", 32'(bus.busy), 32'(0));
    check("ov1.ndx", 32'(bus.new_data), 32'h0c0);
    read_chk(7, 5, base[7] + 16'd5, "ov1.mem");
    clear_nd;

    // Channel 4 re-dumps during its own copy.
    base[4]  = 16'($urandom);
    bus.dump = 12'h010;
    tick;
    bus.dump = '0;
    repeat (2) tick;
    bus.dump = 12'h010;
    tick;
    bus.dump = '0;
    check("ov2.set", 32'(bus.overrun), 32'h090);
    repeat (4) tick;
    check("ov2.nd", 32'(bus.new_data), 32'h010);
    check("ov2.idle", 32'(bus.busy), 32'(0));
    base[4] = 16'($urandom);
    tick;
    check("ov2.again", 32'(bus.busy), 32'(1));
    repeat (6) tick;
    check("ov2.done", 32'(bus.busy), 32'(0));
    for (int w = 0; w < NUM_ACC_WORDS; w++)
      read_chk(4, w, base[4] + 16'(w), "ov2.mem");
    check("ov2.keep", 32'(bus.overrun), 32'h090);
    bus.ov_clr = 1'b1;
    tick;
    bus.ov_clr = 1'b0;
    check("ovclr", 32'(bus.overrun), 32'(0));

    // Reset while channel 5 is at word 3.
    base[5]  = 16'($urandom);
    bus.dump = 12'h020;
    tick;
    bus.dump = '0;
    repeat (4) tick;
    check("mid.busy", 32'(bus.busy), 32'(1));
    check("mid.word", 32'(bus.sel_word), 32'(3));
    rstn = 1'b0;
    tick;
    rstn = 1'b1;
    check("mrst.nd", 32'(bus.new_data), 32'(0));
    check("mrst.ov", 32'(bus.overrun), 32'(0));
    check("mrst.busy", 32'(bus.busy), 32'(0));
    check("mrst.irq", 32'(bus.data_irq), 32'(0));
    check("mrst.sel", 32'(bus.sel_ch), 32'(NCH - 1));
    repeat (10) tick;
    check("mrst.busy2", 32'(bus.busy), 32'(0));
    check("mrst.nd2", 32'(bus.new_data), 32'(0));
    m_last  = NCH - 1;
    base[0] = 16'($urandom);
    run_burst(12'h001, "post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
